// File: rtl/ntt_perm_pkg.sv
// ntt_perm_pkg: shared constants, types and index map for the stage-8 stride permutation
// of the 1024-point, 128-lane NTT pipeline.
package ntt_perm_pkg;
   localparam int NTT_N     = 1024;
   localparam int LANES     = 128;
   localparam int BEATS     = 8;
   localparam int LOG_BEATS = 3;
   localparam int DW        = 28;
   typedef logic [DW-1:0] coeff_t;
   typedef enum logic {IDLE, CAPTURE} cap_state_t;
   // {lane, beat} is 8*lane + beat: the input element shown on output beat/lane
   function automatic logic [9:0] perm_src_index(input logic [LOG_BEATS-1:0] beat, input logic [6:0] lane);
      return {lane, beat};
   endfunction
endpackage

// File: rtl/perm_frame_bank.sv
// perm_frame_bank: one 1024-word frame store with a beat-wide write port
// and a stride-8 (transposed) beat-wide read port.
module perm_frame_bank
   import ntt_perm_pkg::*;
(
   input  logic                 clk,
   input  logic                 i_we,
   input  logic [LOG_BEATS-1:0] i_wbeat,
   input  coeff_t [LANES-1:0]   i_wdata,
   input  logic [LOG_BEATS-1:0] i_rbeat,
   output coeff_t [LANES-1:0]   o_rdata
);
   coeff_t r_mem [NTT_N];
   always_ff @(posedge clk)
      if (i_we)
         for (int l = 0; l < LANES; l++)
            r_mem[{i_wbeat, 7'(l)}] <= i_wdata[l];
   always_comb
      for (int l = 0; l < LANES; l++)
         o_rdata[l] = r_mem[perm_src_index(i_rbeat, 7'(l))];
endmodule

// File: rtl/stage8_permutation.sv
// stage8_permutation: ping-pong corner-turn {cycle,lane} -> {lane,cycle} after NTT stage 8.
// Define STAGE8_PERM_OUTREG_EN for one extra output register stage (latency 9 instead of 8).
module stage8_permutation
   import ntt_perm_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_start,
   input  logic [DW-1:0] inData_0, inData_1, inData_2, inData_3, inData_4, inData_5, inData_6, inData_7, inData_8, inData_9, inData_10, inData_11, inData_12, inData_13, inData_14, inData_15,
      inData_16, inData_17, inData_18, inData_19, inData_20, inData_21, inData_22, inData_23, inData_24, inData_25, inData_26, inData_27, inData_28, inData_29, inData_30, inData_31,
      inData_32, inData_33, inData_34, inData_35, inData_36, inData_37, inData_38, inData_39, inData_40, inData_41, inData_42, inData_43, inData_44, inData_45, inData_46, inData_47,
      inData_48, inData_49, inData_50, inData_51, inData_52, inData_53, inData_54, inData_55, inData_56, inData_57, inData_58, inData_59, inData_60, inData_61, inData_62, inData_63,
      inData_64, inData_65, inData_66, inData_67, inData_68, inData_69, inData_70, inData_71, inData_72, inData_73, inData_74, inData_75, inData_76, inData_77, inData_78, inData_79,
      inData_80, inData_81, inData_82, inData_83, inData_84, inData_85, inData_86, inData_87, inData_88, inData_89, inData_90, inData_91, inData_92, inData_93, inData_94, inData_95,
      inData_96, inData_97, inData_98, inData_99, inData_100, inData_101, inData_102, inData_103, inData_104, inData_105, inData_106, inData_107, inData_108, inData_109, inData_110, inData_111,
      inData_112, inData_113, inData_114, inData_115, inData_116, inData_117, inData_118, inData_119, inData_120, inData_121, inData_122, inData_123, inData_124, inData_125, inData_126, inData_127,
   output logic [DW-1:0] outData_0, outData_1, outData_2, outData_3, outData_4, outData_5, outData_6, outData_7, outData_8, outData_9, outData_10, outData_11, outData_12, outData_13, outData_14, outData_15,
      outData_16, outData_17, outData_18, outData_19, outData_20, outData_21, outData_22, outData_23, outData_24, outData_25, outData_26, outData_27, outData_28, outData_29, outData_30, outData_31,
      outData_32, outData_33, outData_34, outData_35, outData_36, outData_37, outData_38, outData_39, outData_40, outData_41, outData_42, outData_43, outData_44, outData_45, outData_46, outData_47,
      outData_48, outData_49, outData_50, outData_51, outData_52, outData_53, outData_54, outData_55, outData_56, outData_57, outData_58, outData_59, outData_60, outData_61, outData_62, outData_63,
      outData_64, outData_65, outData_66, outData_67, outData_68, outData_69, outData_70, outData_71, outData_72, outData_73, outData_74, outData_75, outData_76, outData_77, outData_78, outData_79,
      outData_80, outData_81, outData_82, outData_83, outData_84, outData_85, outData_86, outData_87, outData_88, outData_89, outData_90, outData_91, outData_92, outData_93, outData_94, outData_95,
      outData_96, outData_97, outData_98, outData_99, outData_100, outData_101, outData_102, outData_103, outData_104, outData_105, outData_106, outData_107, outData_108, outData_109, outData_110, outData_111,
      outData_112, outData_113, outData_114, outData_115, outData_116, outData_117, outData_118, outData_119, outData_120, outData_121, outData_122, outData_123, outData_124, outData_125, outData_126, outData_127,
   output logic          out_start
);
   coeff_t [LANES-1:0]   w_in, w_rd0, w_rd1, w_rd, w_out, r_out;
   cap_state_t           r_state, w_state_nxt;
   logic [LOG_BEATS-1:0] r_wbeat, w_wbeat_nxt, w_wr_beat, r_rbeat, w_rbeat;
   logic                 r_wbank, w_wbank_nxt, w_done, w_we;
   logic                 r_pend, r_emit, r_rbank, w_go, w_rsel, w_rd_en, r_out_start, w_out_start;

   assign w_in = {inData_127, inData_126, inData_125, inData_124, inData_123, inData_122, inData_121, inData_120, inData_119, inData_118, inData_117, inData_116, inData_115, inData_114, inData_113, inData_112,
      inData_111, inData_110, inData_109, inData_108, inData_107, inData_106, inData_105, inData_104, inData_103, inData_102, inData_101, inData_100, inData_99, inData_98, inData_97, inData_96,
      inData_95, inData_94, inData_93, inData_92, inData_91, inData_90, inData_89, inData_88, inData_87, inData_86, inData_85, inData_84, inData_83, inData_82, inData_81, inData_80,
      inData_79, inData_78, inData_77, inData_76, inData_75, inData_74, inData_73, inData_72, inData_71, inData_70, inData_69, inData_68, inData_67, inData_66, inData_65, inData_64,
      inData_63, inData_62, inData_61, inData_60, inData_59, inData_58, inData_57, inData_56, inData_55, inData_54, inData_53, inData_52, inData_51, inData_50, inData_49, inData_48,
      inData_47, inData_46, inData_45, inData_44, inData_43, inData_42, inData_41, inData_40, inData_39, inData_38, inData_37, inData_36, inData_35, inData_34, inData_33, inData_32,
      inData_31, inData_30, inData_29, inData_28, inData_27, inData_26, inData_25, inData_24, inData_23, inData_22, inData_21, inData_20, inData_19, inData_18, inData_17, inData_16,
      inData_15, inData_14, inData_13, inData_12, inData_11, inData_10, inData_9, inData_8, inData_7, inData_6, inData_5, inData_4, inData_3, inData_2, inData_1, inData_0};

   // in_start always (re)starts at beat 0 of the current capture bank, aborting any partial frame
   always_comb begin
      w_state_nxt = r_state;
      w_wbeat_nxt = r_wbeat;
      w_wbank_nxt = r_wbank;
      w_done      = 1'b0;
      w_we        = in_start || r_state == CAPTURE;
      if (in_start) begin
         w_state_nxt = CAPTURE;
         w_wbeat_nxt = 3'd1;
      end else if (r_state == CAPTURE) begin
         w_wbeat_nxt = r_wbeat + 3'd1;
         if (r_wbeat == 3'(BEATS-1)) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
            w_wbank_nxt = ~r_wbank;
         end
      end
   end

   assign w_wr_beat = in_start ? '0 : r_wbeat;
   // a completed frame sits in ~r_wbank until the reader is free
   assign w_go    = r_pend && !r_emit;
   assign w_rsel  = w_go ? ~r_wbank : r_rbank;
   assign w_rbeat = w_go ? '0 : r_rbeat;
   assign w_rd_en = w_go || r_emit;
   assign w_rd    = w_rsel ? w_rd1 : w_rd0;

   perm_frame_bank u_bank0 (.clk, .i_we(w_we && !r_wbank), .i_wbeat(w_wr_beat), .i_wdata(w_in), .i_rbeat(w_rbeat), .o_rdata(w_rd0));
   perm_frame_bank u_bank1 (.clk, .i_we(w_we && r_wbank), .i_wbeat(w_wr_beat), .i_wdata(w_in), .i_rbeat(w_rbeat), .o_rdata(w_rd1));

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state     <= IDLE;
         r_wbeat     <= '0;
         r_wbank     <= 1'b0;
         r_pend      <= 1'b0;
         r_emit      <= 1'b0;
         r_rbeat     <= '0;
         r_rbank     <= 1'b0;
         r_out       <= '0;
         r_out_start <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wbeat     <= w_wbeat_nxt;
         r_wbank     <= w_wbank_nxt;
         r_pend      <= w_done || (r_pend && !w_go);
         r_emit      <= w_go || (r_emit && r_rbeat != 3'(BEATS-1));
         r_rbeat     <= w_rd_en ? w_rbeat + 3'd1 : r_rbeat;
         r_rbank     <= w_rsel;
         r_out       <= w_rd_en ? w_rd : '0;
         r_out_start <= w_go;
      end

`ifdef STAGE8_PERM_OUTREG_EN
   coeff_t [LANES-1:0] r_out_q;
   logic               r_out_start_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_out_q       <= '0;
         r_out_start_q <= 1'b0;
      end else begin
         r_out_q       <= r_out;
         r_out_start_q <= r_out_start;
      end
   assign w_out       = r_out_q;
   assign w_out_start = r_out_start_q;
`else
   assign w_out       = r_out;
   assign w_out_start = r_out_start;
`endif

   assign out_start = w_out_start;
   assign {outData_127, outData_126, outData_125, outData_124, outData_123, outData_122, outData_121, outData_120, outData_119, outData_118, outData_117, outData_116, outData_115, outData_114, outData_113, outData_112,
      outData_111, outData_110, outData_109, outData_108, outData_107, outData_106, outData_105, outData_104, outData_103, outData_102, outData_101, outData_100, outData_99, outData_98, outData_97, outData_96,
      outData_95, outData_94, outData_93, outData_92, outData_91, outData_90, outData_89, outData_88, outData_87, outData_86, outData_85, outData_84, outData_83, outData_82, outData_81, outData_80,
      outData_79, outData_78, outData_77, outData_76, outData_75, outData_74, outData_73, outData_72, outData_71, outData_70, outData_69, outData_68, outData_67, outData_66, outData_65, outData_64,
      outData_63, outData_62, outData_61, outData_60, outData_59, outData_58, outData_57, outData_56, outData_55, outData_54, outData_53, outData_52, outData_51, outData_50, outData_49, outData_48,
      outData_47, outData_46, outData_45, outData_44, outData_43, outData_42, outData_41, outData_40, outData_39, outData_38, outData_37, outData_36, outData_35, outData_34, outData_33, outData_32,
      outData_31, outData_30, outData_29, outData_28, outData_27, outData_26, outData_25, outData_24, outData_23, outData_22, outData_21, outData_20, outData_19, outData_18, outData_17, outData_16,
      outData_15, outData_14, outData_13, outData_12, outData_11, outData_10, outData_9, outData_8, outData_7, outData_6, outData_5, outData_4, outData_3, outData_2, outData_1, outData_0} = w_out;
endmodule

// File: tb/tb_stage8_permutation.sv
// tb_stage8_permutation: directed + random frames checked cycle-by-cycle against a frame-level model
// (output beat b lane l = captured element 8*l+b, LAT cycles after beat-0 edge).
module tb_stage8_permutation;
   localparam int L = 128;
   localparam int W = 28;
`ifdef STAGE8_PERM_OUTREG_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 8;
`endif
   logic clk = 1'b0, rst = 1'b0, in_start = 1'b0;
   logic out_start;
   logic [W-1:0] inData_0, inData_1, inData_2, inData_3, inData_4, inData_5, inData_6, inData_7, inData_8, inData_9, inData_10, inData_11, inData_12, inData_13, inData_14, inData_15,
      inData_16, inData_17, inData_18, inData_19, inData_20, inData_21, inData_22, inData_23, inData_24, inData_25, inData_26, inData_27, inData_28, inData_29, inData_30, inData_31,
      inData_32, inData_33, inData_34, inData_35, inData_36, inData_37, inData_38, inData_39, inData_40, inData_41, inData_42, inData_43, inData_44, inData_45, inData_46, inData_47,
      inData_48, inData_49, inData_50, inData_51, inData_52, inData_53, inData_54, inData_55, inData_56, inData_57, inData_58, inData_59, inData_60, inData_61, inData_62, inData_63,
      inData_64, inData_65, inData_66, inData_67, inData_68, inData_69, inData_70, inData_71, inData_72, inData_73, inData_74, inData_75, inData_76, inData_77, inData_78, inData_79,
      inData_80, inData_81, inData_82, inData_83, inData_84, inData_85, inData_86, inData_87, inData_88, inData_89, inData_90, inData_91, inData_92, inData_93, inData_94, inData_95,
      inData_96, inData_97, inData_98, inData_99, inData_100, inData_101, inData_102, inData_103, inData_104, inData_105, inData_106, inData_107, inData_108, inData_109, inData_110, inData_111,
      inData_112, inData_113, inData_114, inData_115, inData_116, inData_117, inData_118, inData_119, inData_120, inData_121, inData_122, inData_123, inData_124, inData_125, inData_126, inData_127;
   logic [W-1:0] outData_0, outData_1, outData_2, outData_3, outData_4, outData_5, outData_6, outData_7, outData_8, outData_9, outData_10, outData_11, outData_12, outData_13, outData_14, outData_15,
      outData_16, outData_17, outData_18, outData_19, outData_20, outData_21, outData_22, outData_23, outData_24, outData_25, outData_26, outData_27, outData_28, outData_29, outData_30, outData_31,
      outData_32, outData_33, outData_34, outData_35, outData_36, outData_37, outData_38, outData_39, outData_40, outData_41, outData_42, outData_43, outData_44, outData_45, outData_46, outData_47,
      outData_48, outData_49, outData_50, outData_51, outData_52, outData_53, outData_54, outData_55, outData_56, outData_57, outData_58, outData_59, outData_60, outData_61, outData_62, outData_63,
      outData_64, outData_65, outData_66, outData_67, outData_68, outData_69, outData_70, outData_71, outData_72, outData_73, outData_74, outData_75, outData_76, outData_77, outData_78, outData_79,
      outData_80, outData_81, outData_82, outData_83, outData_84, outData_85, outData_86, outData_87, outData_88, outData_89, outData_90, outData_91, outData_92, outData_93, outData_94, outData_95,
      outData_96, outData_97, outData_98, outData_99, outData_100, outData_101, outData_102, outData_103, outData_104, outData_105, outData_106, outData_107, outData_108, outData_109, outData_110, outData_111,
      outData_112, outData_113, outData_114, outData_115, outData_116, outData_117, outData_118, outData_119, outData_120, outData_121, outData_122, outData_123, outData_124, outData_125, outData_126, outData_127;
   logic [L*W-1:0] in_flat = '0;
   logic [L*W-1:0] out_flat;

   assign {inData_127, inData_126, inData_125, inData_124, inData_123, inData_122, inData_121, inData_120, inData_119, inData_118, inData_117, inData_116, inData_115, inData_114, inData_113, inData_112,
      inData_111, inData_110, inData_109, inData_108, inData_107, inData_106, inData_105, inData_104, inData_103, inData_102, inData_101, inData_100, inData_99, inData_98, inData_97, inData_96,
      inData_95, inData_94, inData_93, inData_92, inData_91, inData_90, inData_89, inData_88, inData_87, inData_86, inData_85, inData_84, inData_83, inData_82, inData_81, inData_80,
      inData_79, inData_78, inData_77, inData_76, inData_75, inData_74, inData_73, inData_72, inData_71, inData_70, inData_69, inData_68, inData_67, inData_66, inData_65, inData_64,
      inData_63, inData_62, inData_61, inData_60, inData_59, inData_58, inData_57, inData_56, inData_55, inData_54, inData_53, inData_52, inData_51, inData_50, inData_49, inData_48,
      inData_47, inData_46, inData_45, inData_44, inData_43, inData_42, inData_41, inData_40, inData_39, inData_38, inData_37, inData_36, inData_35, inData_34, inData_33, inData_32,
      inData_31, inData_30, inData_29, inData_28, inData_27, inData_26, inData_25, inData_24, inData_23, inData_22, inData_21, inData_20, inData_19, inData_18, inData_17, inData_16,
      inData_15, inData_14, inData_13, inData_12, inData_11, inData_10, inData_9, inData_8, inData_7, inData_6, inData_5, inData_4, inData_3, inData_2, inData_1, inData_0} = in_flat;
   assign out_flat = {outData_127, outData_126, outData_125, outData_124, outData_123, outData_122, outData_121, outData_120, outData_119, outData_118, outData_117, outData_116, outData_115, outData_114, outData_113, outData_112,
      outData_111, outData_110, outData_109, outData_108, outData_107, outData_106, outData_105, outData_104, outData_103, outData_102, outData_101, outData_100, outData_99, outData_98, outData_97, outData_96,
      outData_95, outData_94, outData_93, outData_92, outData_91, outData_90, outData_89, outData_88, outData_87, outData_86, outData_85, outData_84, outData_83, outData_82, outData_81, outData_80,
      outData_79, outData_78, outData_77, outData_76, outData_75, outData_74, outData_73, outData_72, outData_71, outData_70, outData_69, outData_68, outData_67, outData_66, outData_65, outData_64,
      outData_63, outData_62, outData_61, outData_60, outData_59, outData_58, outData_57, outData_56, outData_55, outData_54, outData_53, outData_52, outData_51, outData_50, outData_49, outData_48,
      outData_47, outData_46, outData_45, outData_44, outData_43, outData_42, outData_41, outData_40, outData_39, outData_38, outData_37, outData_36, outData_35, outData_34, outData_33, outData_32,
      outData_31, outData_30, outData_29, outData_28, outData_27, outData_26, outData_25, outData_24, outData_23, outData_22, outData_21, outData_20, outData_19, outData_18, outData_17, outData_16,
      outData_15, outData_14, outData_13, outData_12, outData_11, outData_10, outData_9, outData_8, outData_7, outData_6, outData_5, outData_4, outData_3, outData_2, outData_1, outData_0};

   stage8_permutation dut (.clk, .rst, .in_start, .out_start,
      .inData_0, .inData_1, .inData_2, .inData_3, .inData_4, .inData_5, .inData_6, .inData_7, .inData_8, .inData_9, .inData_10, .inData_11, .inData_12, .inData_13, .inData_14, .inData_15,
      .inData_16, .inData_17, .inData_18, .inData_19, .inData_20, .inData_21, .inData_22, .inData_23, .inData_24, .inData_25, .inData_26, .inData_27, .inData_28, .inData_29, .inData_30, .inData_31,
      .inData_32, .inData_33, .inData_34, .inData_35, .inData_36, .inData_37, .inData_38, .inData_39, .inData_40, .inData_41, .inData_42, .inData_43, .inData_44, .inData_45, .inData_46, .inData_47,
      .inData_48, .inData_49, .inData_50, .inData_51, .inData_52, .inData_53, .inData_54, .inData_55, .inData_56, .inData_57, .inData_58, .inData_59, .inData_60, .inData_61, .inData_62, .inData_63,
      .inData_64, .inData_65, .inData_66, .inData_67, .inData_68, .inData_69, .inData_70, .inData_71, .inData_72, .inData_73, .inData_74, .inData_75, .inData_76, .inData_77, .inData_78, .inData_79,
      .inData_80, .inData_81, .inData_82, .inData_83, .inData_84, .inData_85, .inData_86, .inData_87, .inData_88, .inData_89, .inData_90, .inData_91, .inData_92, .inData_93, .inData_94, .inData_95,
      .inData_96, .inData_97, .inData_98, .inData_99, .inData_100, .inData_101, .inData_102, .inData_103, .inData_104, .inData_105, .inData_106, .inData_107, .inData_108, .inData_109, .inData_110, .inData_111,
      .inData_112, .inData_113, .inData_114, .inData_115, .inData_116, .inData_117, .inData_118, .inData_119, .inData_120, .inData_121, .inData_122, .inData_123, .inData_124, .inData_125, .inData_126, .inData_127,
      .outData_0, .outData_1, .outData_2, .outData_3, .outData_4, .outData_5, .outData_6, .outData_7, .outData_8, .outData_9, .outData_10, .outData_11, .outData_12, .outData_13, .outData_14, .outData_15,
      .outData_16, .outData_17, .outData_18, .outData_19, .outData_20, .outData_21, .outData_22, .outData_23, .outData_24, .outData_25, .outData_26, .outData_27, .outData_28, .outData_29, .outData_30, .outData_31,
      .outData_32, .outData_33, .outData_34, .outData_35, .outData_36, .outData_37, .outData_38, .outData_39, .outData_40, .outData_41, .outData_42, .outData_43, .outData_44, .outData_45, .outData_46, .outData_47,
      .outData_48, .outData_49, .outData_50, .outData_51, .outData_52, .outData_53, .outData_54, .outData_55, .outData_56, .outData_57, .outData_58, .outData_59, .outData_60, .outData_61, .outData_62, .outData_63,
      .outData_64, .outData_65, .outData_66, .outData_67, .outData_68, .outData_69, .outData_70, .outData_71, .outData_72, .outData_73, .outData_74, .outData_75, .outData_76, .outData_77, .outData_78, .outData_79,
      .outData_80, .outData_81, .outData_82, .outData_83, .outData_84, .outData_85, .outData_86, .outData_87, .outData_88, .outData_89, .outData_90, .outData_91, .outData_92, .outData_93, .outData_94, .outData_95,
      .outData_96, .outData_97, .outData_98, .outData_99, .outData_100, .outData_101, .outData_102, .outData_103, .outData_104, .outData_105, .outData_106, .outData_107, .outData_108, .outData_109, .outData_110, .outData_111,
      .outData_112, .outData_113, .outData_114, .outData_115, .outData_116, .outData_117, .outData_118, .outData_119, .outData_120, .outData_121, .outData_122, .outData_123, .outData_124, .outData_125, .outData_126, .outData_127);

   always #5 clk = ~clk;

   int n_total = 0, n_bad = 0, cyc = 0;
   logic [W-1:0] drv [L];
   logic [W-1:0] frame [1024];
   logic [L*W-1:0] exp_beat [int];
   bit exp_st [int];
   bit capturing = 1'b0;
   int cap_beat = 0, cap_edge = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, want);
      end
   endtask

   // a completed frame appears LAT edges after its beat-0 edge, transposed
   task automatic schedule_frame(input int e0);
      for (int b = 0; b < 8; b++) begin
         logic [L*W-1:0] v;
         for (int l = 0; l < L; l++) v[l*W +: W] = frame[8*l+b];
         exp_beat[e0+LAT+b] = v;
      end
      exp_st[e0+LAT] = 1'b1;
   endtask

   task automatic check_cycle(input string tag);
      logic [L*W-1:0] e;
      e = exp_beat.exists(cyc) ? exp_beat[cyc] : '0;
      chk($sformatf("%s c%0d start", tag, cyc), 32'(out_start), 32'(exp_st.exists(cyc)));
      for (int l = 0; l < L; l++)
         chk($sformatf("%s c%0d lane%0d", tag, cyc, l), 32'(out_flat[l*W +: W]), 32'(e[l*W +: W]));
   endtask

   task automatic step(input string tag, input bit st);
      in_start = st;
      for (int l = 0; l < L; l++) in_flat[l*W +: W] = drv[l];
      if (st) begin
         capturing = 1'b1;
         cap_beat  = 0;
         cap_edge  = cyc + 1;
      end
      if (capturing) begin
         for (int l = 0; l < L; l++) frame[L*cap_beat+l] = drv[l];
         cap_beat++;
         if (cap_beat == 8) begin
            capturing = 1'b0;
            schedule_frame(cap_edge);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      check_cycle(tag);
   endtask

   task automatic zero_drv();
      for (int l = 0; l < L; l++) drv[l] = '0;
   endtask

   task automatic async_reset();
      int ks[$];
      rst = 1'b0;
      #1;
      capturing = 1'b0;
      foreach (exp_beat[k]) if (k >= cyc) ks.push_back(k);
      foreach (ks[i]) begin
         exp_beat.delete(ks[i]);
         if (exp_st.exists(ks[i])) exp_st.delete(ks[i]);
      end
      check_cycle("async_rst");
      zero_drv();
      step("in_rst", 1'b0);
      step("in_rst", 1'b0);
      rst = 1'b1;
   endtask

   initial begin
      zero_drv();
      step("reset", 1'b0);
      step("reset", 1'b0);
      rst = 1'b1;
      for (int b = 0; b < 8; b++) begin
         for (int l = 0; l < L; l++) drv[l] = 28'(128*b + l);
         step("single", b == 0);
      end
      zero_drv();
      repeat (12) step("single_tail", 1'b0);
      for (int f = 0; f < 2; f++)
         for (int b = 0; b < 8; b++) begin
            for (int l = 0; l < L; l++) drv[l] = 28'(1024*f + 128*b + l);
            step("b2b", b == 0);
         end
      zero_drv();
      repeat (12) step("b2b_tail", 1'b0);
      for (int b = 0; b < 3; b++) begin
         for (int l = 0; l < L; l++) drv[l] = 28'(5000 + 128*b + l);
         step("abort", b == 0);
      end
      for (int b = 0; b < 8; b++) begin
         for (int l = 0; l < L; l++) drv[l] = 28'(2048 + 128*b + l);
         step("restart", b == 0);
      end
      zero_drv();
      repeat (12) step("restart_tail", 1'b0);
      for (int b = 0; b < 8; b++) begin
         for (int l = 0; l < L; l++) drv[l] = 28'($urandom);
         step("pre_rst", b == 0);
      end
      zero_drv();
      repeat (3) step("pre_rst_out", 1'b0);
      async_reset();
      repeat (12) step("post_rst", 1'b0);
      for (int b = 0; b < 8; b++) begin
         zero_drv();
         if (b == 5) drv[0] = 28'hFFFFFFF;
         step("ones", b == 0);
      end
      zero_drv();
      repeat (12) step("ones_tail", 1'b0);
      for (int f = 0, prev_abort = 0; f < 40; f++) begin
         int nb;
         if (prev_abort == 0)
            repeat ($urandom_range(0, 4)) begin
               for (int l = 0; l < L; l++) drv[l] = 28'($urandom);
               step("rnd_idle", 1'b0);
            end
         prev_abort = ($urandom_range(0, 5) == 0) ? 1 : 0;
         nb = (prev_abort != 0) ? $urandom_range(1, 7) : 8;
         for (int b = 0; b < nb; b++) begin
            for (int l = 0; l < L; l++) drv[l] = 28'($urandom);
            step("rnd", b == 0);
         end
      end
      zero_drv();
      repeat (20) step("rnd_tail", 1'b0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
